// File: rtl/pipe_stage_fifo.sv
// Elastic stage buffer: DEPTH-entry valid/ready queue between two stages.
// Ports: clk, reset (async low), in_*/out_* handshakes, flush, count.
module pipe_stage_fifo #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned DEPTH        = 2,
  parameter bit          DROP_BUBBLES = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_bubble,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_bubble,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            enq, deq;
  logic [WIDTH:0]  head;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // in_ready looks only at registered occupancy,
  // so a full buffer stays closed even while it drains.
  assign in_ready  = (cnt_q < FULL);
  assign out_valid = (cnt_q != '0);

  assign enq = in_valid & in_ready & ~flush
             & ~(DROP_BUBBLES & in_bubble);
  assign deq = out_valid & out_ready;

  assign head       = mem_q[rd_q];
  assign out_data   = out_valid ? head[WIDTH-1:0] : '0;
  assign out_bubble = out_valid ? head[WIDTH] : 1'b1;
  assign count      = cnt_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (enq) wr_d = nxt(wr_q);
      if (deq) rd_d = nxt(rd_q);
      cnt_d = cnt_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (enq && reset) mem_q[wr_q] <= {in_bubble, in_data};
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: four configurations share one stimulus
// stream; a queue model per instance feeds a negedge monitor.
module tb_pipe_stage_fifo;

  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_bubble = 1'b0;
  logic out_ready = 1'b0;
  logic flush = 1'b0;
  logic [W-1:0] in_data = '0;

  logic [N-1:0]         ir, ov, ob;
  logic [N-1:0][W-1:0]  od;
  logic [N-1:0][3:0]    cn;

  logic [W:0]   exq [N][$];
  logic [N-1:0] pn = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int dep(int g);
    case (g)
      0: return 2;
      1: return 3;
      2: return 1;
      default: return 5;
    endcase
  endfunction

  function automatic bit drp(int g);
    return (g == 1) || (g == 3);
  endfunction

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int D = (g == 0) ? 2 : (g == 1) ? 3 :
                       (g == 2) ? 1 : 5;
    localparam bit B = (g == 1) || (g == 3);
    logic [$clog2(D+1)-1:0] c;
    logic r, v, b;
    logic [W-1:0] d;
    pipe_stage_fifo #(
      .WIDTH(W), .DEPTH(D), .DROP_BUBBLES(B)
    ) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(r),
      .in_data(in_data), .in_bubble(in_bubble),
      .out_valid(v), .out_ready(out_ready),
      .out_data(d), .out_bubble(b),
      .flush(flush), .count(c)
    );
    assign ir[g] = r;
    assign ov[g] = v;
    assign ob[g] = b;
    assign od[g] = d;
    assign cn[g] = 4'(c);
  end

  task automatic chk(string nm, int g,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d act=%0h exp=%0h t=%0t",
               nm, g, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and record what the model accepts.
  task automatic drive(logic v, logic [W-1:0] d, logic b,
                       logic ordy, logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_bubble = b;
    out_ready = ordy;
    flush     = fl;
    for (int g = 0; g < N; g++) begin
      bit rdy;
      rdy = exq[g].size() < dep(g);
      pn[g] = v & rdy & ~fl & ~(drp(g) & b);
      if (pn[g]) exq[g].push_back({b, d});
    end
  endtask

  // Monitor: compare every instance against its model each cycle.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      int occ;
      logic [W:0] h;
      occ = exq[g].size() - int'(pn[g]);
      h = (occ != 0) ? exq[g][0] : {1'b1, {W{1'b0}}};
      chk("in_ready", g, 32'(ir[g]), 32'(occ < dep(g)));
      chk("out_valid", g, 32'(ov[g]), 32'(occ != 0));
      chk("count", g, 32'(cn[g]), 32'(occ));
      chk("out_bubble", g, 32'(ob[g]), 32'(h[W]));
      chk("out_data", g, 32'(od[g]), 32'(h[W-1:0]));
      if (occ != 0 && out_ready) void'(exq[g].pop_front());
      if (flush) exq[g].delete();
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Back-to-back stream with consumer always ready.
    drive(1, 16'h1000, 0, 1, 0);
    drive(1, 16'h1004, 0, 1, 0);
    drive(1, 16'h1008, 0, 1, 0);
    drive(0, 16'h0, 0, 1, 0);
    repeat (3) drive(0, 16'h0, 0, 1, 0);

    // Fill under back-pressure, then drain.
    for (int i = 1; i <= 6; i++) drive(1, 16'(i), 0, 0, 0);
    repeat (8) drive(0, 16'h0, 0, 1, 0);

    // Two entries then flush with a competing input.
    drive(1, 16'h000A, 0, 0, 0);
    drive(1, 16'h000B, 0, 0, 0);
    drive(1, 16'h000C, 0, 1, 1);
    drive(0, 16'h0, 0, 1, 0);
    drive(0, 16'h0, 0, 1, 0);

    // Bubble in the middle of a stream.
    drive(1, 16'h0010, 0, 1, 0);
    drive(1, 16'h0020, 1, 1, 0);
    drive(1, 16'h0030, 0, 1, 0);
    repeat (6) drive(0, 16'h0, 0, 1, 0);

    // Randomised phases.
    for (int p = 0; p < 30; p++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 20; i++) begin
        logic v, b, o, f;
        v = ($urandom_range(0, 3) != 0);
        b = ($urandom_range(0, 3) == 0);
        o = ($urandom_range(0, 1) == 1);
        f = ($urandom_range(0, 15) == 0);
        if (mode == 1) begin o = 1'b0; f = 1'b0; end
        if (mode == 2) begin v = 1'b1; o = 1'b1; f = 1'b0; end
        drive(v, 16'($urandom), b, o, f);
      end
    end

    // Fill, then async reset between edges.
    for (int i = 0; i < 6; i++) drive(1, 16'(5 + i), 0, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    in_valid = 1'b0;
    for (int g = 0; g < N; g++) exq[g].delete();
    pn = '0;
    #1;
    for (int g = 0; g < N; g++) begin
      chk("rst_in_ready", g, 32'(ir[g]), 32'd1);
      chk("rst_out_valid", g, 32'(ov[g]), 32'd0);
      chk("rst_count", g, 32'(cn[g]), 32'd0);
      chk("rst_out_bubble", g, 32'(ob[g]), 32'd1);
      chk("rst_out_data", g, 32'(od[g]), 32'd0);
    end
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 100; i++) begin
      drive(($urandom_range(0, 3) != 0), 16'($urandom),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 19) == 0));
    end
    drive(0, 16'h0, 0, 1, 0);
    @(posedge clk);
    #6;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
